// File: rtl/ft_cmd_pkg.sv
// Opcode, response and state encodings shared by the FT600 command engine,
// its register file and the host-side tooling.
package ft_cmd_pkg;

    localparam int ADDR_FIELD_W = 4;

    localparam logic [3:0] OP_WRITE    = 4'h1;
    localparam logic [3:0] OP_READ     = 4'h2;
    localparam logic [3:0] OP_STREAM   = 4'h3;
    localparam logic [3:0] OP_ECHO     = 4'h4;
    localparam logic [3:0] OP_ERR_RESP = 4'hF;
    localparam logic [7:0] ERR_BYTE    = 8'hEE;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_ARG   = 3'd1,
        ST_EXEC  = 3'd2,
        ST_RESP  = 3'd3,
        ST_STRM  = 3'd4
    } state_e;

    function automatic logic needs_arg(input logic [3:0] op);
        return (op == OP_STREAM) || (op == OP_ECHO);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return (op == OP_WRITE) || (op == OP_READ) || (op == OP_STREAM) || (op == OP_ECHO);
    endfunction

endpackage

// File: rtl/ft_cmd_regfile.sv
// Small 8-bit register file: synchronous write, combinational read,
// register 0 exported to the board LEDs.
module ft_cmd_regfile
    import ft_cmd_pkg::*;
#(
    parameter int AW = ADDR_FIELD_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o,
    output logic [7:0]    led_o
);

    logic [7:0] regs_q [2**AW];

    // NOTE: the array is reset element by element because software relies on
    // every register reading 0x00 after reset; this keeps it out of RAM macros.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**AW; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (wr_en_i) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = regs_q[rd_addr_i];
    assign led_o     = regs_q[0];

endmodule

// File: rtl/ft_cmd_engine.sv
// Host command engine on the FT600 bridge FIFOs: register write/read, echo
// and counting streams, answered through the TX FIFO strictly in order.
module ft_cmd_engine
    import ft_cmd_pkg::*;
#(
    parameter int NREG_W   = 4,
    parameter int STREAM_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rx_en,
    input  logic [15:0] rx_data,
    input  logic        rx_empty,
    output logic        tx_en,
    output logic [15:0] tx_data,
    input  logic        tx_full,
    output logic [7:0]  led,
    output logic        busy,
    output logic [7:0]  err_count
);

    localparam int AW    = (NREG_W > ADDR_FIELD_W) ? ADDR_FIELD_W : NREG_W;
    localparam int NREGS = 1 << AW;

    state_e              state_q;
    logic [15:0]         cmd_q;
    logic [15:0]         arg_q;
    logic [15:0]         tx_data_q;
    logic [STREAM_W-1:0] k_q;
    logic [7:0]          err_count_q;

    logic [3:0]          cmd_op;
    logic [3:0]          cmd_addr;
    logic [7:0]          cmd_imm;
    logic                addr_ok;
    logic                wr_en;
    logic [7:0]          rd_data;
    logic [7:0]          k_lo;
    logic [STREAM_W-1:0] n_words;
    logic [15:0]         resp;

    assign cmd_op   = cmd_q[15:12];
    assign cmd_addr = cmd_q[11:8];
    assign cmd_imm  = cmd_q[7:0];
    assign addr_ok  = int'(cmd_addr) < NREGS;
    assign n_words  = arg_q[STREAM_W-1:0];
    assign k_lo     = k_q[7:0];
    assign wr_en    = (state_q == ST_EXEC) && (cmd_op == OP_WRITE) && addr_ok;

    ft_cmd_regfile #(.AW(AW)) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_addr_i (cmd_q[8 +: AW]),
        .wr_data_i (cmd_imm),
        .rd_addr_i (cmd_q[8 +: AW]),
        .rd_data_o (rd_data),
        .led_o     (led)
    );

    // NOTE: every path assigns resp first, so this block cannot infer a latch.
    always_comb begin
        resp = {OP_ERR_RESP, cmd_addr, ERR_BYTE};
        case (cmd_op)
            OP_WRITE: resp = {OP_WRITE, cmd_addr, cmd_imm};
            OP_READ:  resp = {OP_READ, cmd_addr, addr_ok ? rd_data : 8'h00};
            OP_ECHO:  resp = arg_q;
            default:  ;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            cmd_q       <= '0;
            arg_q       <= '0;
            tx_data_q   <= '0;
            k_q         <= '0;
            err_count_q <= '0;
        end else begin
            case (state_q)
                ST_FETCH: if (!rx_empty) begin
                    cmd_q   <= rx_data;
                    state_q <= needs_arg(rx_data[15:12]) ? ST_ARG : ST_EXEC;
                end
                ST_ARG: if (!rx_empty) begin
                    arg_q   <= rx_data;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    k_q <= '0;
                    if (cmd_op == OP_STREAM) begin
                        state_q <= (n_words == '0) ? ST_FETCH : ST_STRM;
                    end else begin
                        tx_data_q <= resp;
                        state_q   <= ST_RESP;
                        if (!is_legal(cmd_op) && err_count_q != 8'hFF) begin
                            err_count_q <= err_count_q + 8'd1;
                        end
                    end
                end
                ST_RESP: if (!tx_full) state_q <= ST_FETCH;
                ST_STRM: if (!tx_full) begin
                    if (k_q == n_words - STREAM_W'(1)) state_q <= ST_FETCH;
                    else                               k_q     <= k_q + STREAM_W'(1);
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    // Handshakes are gated by rst so an aborted command never moves a word.
    assign rx_en     = !rst && (state_q == ST_FETCH || state_q == ST_ARG) && !rx_empty;
    assign tx_en     = !rst && (state_q == ST_RESP || state_q == ST_STRM) && !tx_full;
    assign tx_data   = (state_q == ST_STRM) ? {k_lo, k_lo} : tx_data_q;
    assign busy      = (state_q != ST_FETCH);
    assign err_count = err_count_q;

endmodule

// File: tb/tb_ft_cmd_engine.sv
// Directed bench for ft_cmd_engine: an RX FIFO model feeds commands, expected
// TX words go into a scoreboard queue checked by an independent monitor.
module tb_ft_cmd_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_en;
    logic [15:0] rx_data = 16'h0000;
    logic        rx_empty = 1'b1;
    logic        tx_en;
    logic [15:0] tx_data;
    logic        tx_full = 1'b0;
    logic [7:0]  led;
    logic        busy;
    logic [7:0]  err_count;

    logic [15:0] rx_q[$];
    logic [15:0] exp_q[$];
    logic        tx_full_req = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          tx_seen = 0;

    ft_cmd_engine #(.NREG_W(4), .STREAM_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_en     (rx_en),
        .rx_data   (rx_data),
        .rx_empty  (rx_empty),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .tx_full   (tx_full),
        .led       (led),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // RX FIFO model: inputs change on the falling edge, a pop is taken for the
    // coming rising edge, and the head stays put until the next falling edge.
    initial forever begin
        @(negedge clk);
        rx_empty = (rx_q.size() == 0);
        rx_data  = (rx_q.size() != 0) ? rx_q[0] : 16'h0000;
        tx_full  = tx_full_req;
        #1;
        if (rx_en && rx_empty) begin
            checks++; errors++;
            $display("FAIL rx_en_while_empty: got rx_en=1, expected 0");
        end
        if (rx_en && rx_q.size() != 0) void'(rx_q.pop_front());
    end

    // Monitor: every push the DUT commits at the next rising edge is compared
    // with the head of the scoreboard.
    initial forever begin
        @(negedge clk);
        #2;
        if (tx_en && tx_full) begin
            checks++; errors++;
            $display("FAIL tx_en_while_full: got tx_en=1, expected 0");
        end
        if (tx_en) begin
            tx_seen++;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_tx: got 0x%04h, expected no push", tx_data);
            end else begin
                check("tx_word", {16'h0, tx_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #3;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (exp_q.size() == 0 && rx_q.size() == 0 && !busy) return;
        end
        checks++; errors++;
        $display("FAIL timeout_%s: got %0d words pending, expected 0", name, exp_q.size());
    endtask

    task automatic wait_tx(input string name, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (tx_seen >= target) return;
            step();
        end
        checks++; errors++;
        $display("FAIL timeout_%s: got %0d pushes, expected %0d", name, tx_seen, target);
    endtask

    initial begin
        int base;

        // Reset values
        repeat (3) step();
        check("reset_busy", {31'h0, busy}, 0);
        check("reset_led", {24'h0, led}, 0);
        check("reset_err", {24'h0, err_count}, 0);
        check("reset_txdata", {16'h0, tx_data}, 0);
        check("reset_rx_en", {31'h0, rx_en}, 0);
        check("reset_tx_en", {31'h0, tx_en}, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // WRITE then READ, plus the top register
        rx_q.push_back(16'h1055); exp_q.push_back(16'h1055);
        rx_q.push_back(16'h2000); exp_q.push_back(16'h2055);
        rx_q.push_back(16'h1F3C); exp_q.push_back(16'h1F3C);
        rx_q.push_back(16'h2F00); exp_q.push_back(16'h2F3C);
        wait_idle("write_read", 100);
        check("led_after_write", {24'h0, led}, 32'h55);

        // STREAM N=5 with tx_full raised after the first word for three cycles
        base = tx_seen;
        rx_q.push_back(16'h3000);
        rx_q.push_back(16'h0005);
        for (int k = 0; k < 5; k++) exp_q.push_back({k[7:0], k[7:0]});
        wait_tx("stream_first", base + 1, 50);
        tx_full_req = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        tx_full_req = 1'b0;
        wait_idle("stream5", 100);
        check("stream5_count", tx_seen - base, 5);

        // STREAM N=0: no word, busy back low three cycles after the command pop
        rx_q.push_back(16'h3000);
        rx_q.push_back(16'h0000);
        step();
        check("n0_pop", {31'h0, rx_en}, 1);
        check("n0_busy_t0", {31'h0, busy}, 0);
        step();
        check("n0_busy_t1", {31'h0, busy}, 1);
        step();
        check("n0_busy_t2", {31'h0, busy}, 1);
        step();
        check("n0_busy_t3", {31'h0, busy}, 0);

        // ECHO with the argument arriving ten cycles late
        rx_q.push_back(16'h4000);
        exp_q.push_back(16'hBEEF);
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            check("echo_wait_rx_en", {31'h0, rx_en}, 0);
        end
        check("echo_wait_busy", {31'h0, busy}, 1);
        rx_q.push_back(16'hBEEF);
        wait_idle("echo", 50);

        // Illegal opcodes, enough to saturate the error counter
        for (int i = 0; i < 300; i++) begin
            rx_q.push_back(16'h7123);
            exp_q.push_back(16'hF1EE);
        end
        wait_idle("illegal", 2000);
        check("err_saturated", {24'h0, err_count}, 32'hFF);
        rx_q.push_back(16'h0A12); exp_q.push_back(16'hFAEE);
        wait_idle("illegal_op0", 50);
        check("err_held", {24'h0, err_count}, 32'hFF);

        // Reset after the 10th word of a 100-word stream
        base = tx_seen;
        rx_q.push_back(16'h3000);
        rx_q.push_back(16'h0064);
        for (int k = 0; k < 10; k++) exp_q.push_back({k[7:0], k[7:0]});
        wait_tx("stream100", base + 10, 100);
        @(negedge clk);
        rst = 1'b1;
        #3;
        check("abort_tx_en", {31'h0, tx_en}, 0);
        repeat (2) step();
        @(negedge clk);
        rst = 1'b0;
        #3;
        check("abort_count", tx_seen - base, 10);
        check("abort_led", {24'h0, led}, 0);
        check("abort_err", {24'h0, err_count}, 0);
        check("abort_busy", {31'h0, busy}, 0);
        repeat (5) step();
        check("abort_no_more_tx", tx_seen - base, 10);
        rx_q.push_back(16'h2000); exp_q.push_back(16'h2000);
        wait_idle("read_after_reset", 50);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
